// File: rtl/wb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_mux_pkg
// Brief    : Shared FSM state type, index-width helper and default error word
//            for the Wishbone slave fan-out.
// Revision : 1.0 - initial release
// ============================================================================
package wb_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } mux_state_t;

  localparam logic [31:0] c_err_data_default = 32'hBADD_ADD0;

  // One extra code point so the optional statistics window can be indexed.
  function automatic int idx_width(input int n_slv);
    return $clog2(n_slv + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mux_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_mux_watchdog
// Brief    : Cycle counter that flags expiry after TIMEOUT enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mux_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] r_count;

  // Flags the last permitted cycle so the owner can act on this edge,
  // giving exactly TIMEOUT enabled cycles before expiry takes effect.
  assign expire = (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_slave_mux
// Brief    : Wishbone classic fan-out to N_SLV windowed slaves with registered
//            responses, decode-miss error reply and per-access watchdog.
//            Optional macro WB_MUX_STATS_EN adds an internal counter window.
// Revision : 1.0 - initial release
// ============================================================================
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int              N_SLV     = 4,
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = AW'(32'h3000_0000),
  parameter int              WIN_BITS  = 20,
  parameter int              TIMEOUT   = 255,
  parameter logic [DW-1:0]   ERR_DATA  = DW'(c_err_data_default)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DW/8-1:0]     wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    m_cyc_o,
  output logic [N_SLV-1:0]    m_stb_o,
  output logic                m_we_o,
  output logic [DW/8-1:0]     m_sel_o,
  output logic [WIN_BITS-1:0] m_adr_o,
  output logic [DW-1:0]       m_dat_o,
  input  logic [N_SLV*DW-1:0] m_dat_i,
  input  logic [N_SLV-1:0]    m_ack_i,
  output logic                err_irq_o
);

  localparam int c_iw = idx_width(N_SLV);
  localparam int c_xw = AW - WIN_BITS;

  mux_state_t          r_state;
  mux_state_t          w_state_next;

  logic [N_SLV-1:0]    r_stb;
  logic                r_we;
  logic [DW/8-1:0]     r_sel;
  logic [WIN_BITS-1:0] r_adr;
  logic [DW-1:0]       r_wdat;
  logic                r_ack;
  logic [DW-1:0]       r_rdat;
  logic                r_err;

  logic [AW-1:0]       w_off;
  logic [c_xw-1:0]     w_win;
  logic [c_iw-1:0]     w_idx;
  logic [N_SLV-1:0]    w_onehot;
  logic                w_above;
  logic                w_hit;
  logic                w_req;

  logic                w_sel_ack;
  logic [DW-1:0]       w_slv_rdata;

  logic                w_issue;
  logic                w_miss;
  logic                w_done;
  logic                w_tmo;
  logic                w_abort;
  logic                w_wd_clr;
  logic                w_wd_en;
  logic                w_wd_expire;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_req    = wbs_cyc_i & wbs_stb_i;
  assign w_off    = wbs_adr_i - BASE_ADDR;
  assign w_win    = w_off[AW-1:WIN_BITS];
  assign w_idx    = w_win[c_iw-1:0];
  assign w_above  = (wbs_adr_i >= BASE_ADDR);
  assign w_hit    = w_above && (w_win < c_xw'(N_SLV));
  assign w_onehot = N_SLV'(1) << w_idx;

  // r_stb is one-hot while busy, so it doubles as the response select.
  assign w_sel_ack = |(m_ack_i & r_stb);

  always_comb begin
    w_slv_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (r_stb[k]) begin
        w_slv_rdata = w_slv_rdata | m_dat_i[k*DW +: DW];
      end
    end
  end

`ifdef WB_MUX_STATS_EN
  localparam int c_bw = $clog2(DW / 8);
  localparam int c_ww = WIN_BITS - c_bw;

  logic              w_stats_win;
  logic              w_stats_acc;
  logic [c_ww-1:0]   w_word;
  logic [DW-1:0]     w_stats_rdata;
  logic [15:0]       r_ack_cnt [N_SLV];
  logic [15:0]       r_miss_cnt;
  logic [15:0]       r_tmo_cnt;

  assign w_stats_win = w_above && (w_win == c_xw'(N_SLV));
  assign w_word      = w_off[WIN_BITS-1:c_bw];

  always_comb begin
    w_stats_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (w_word == c_ww'(k)) begin
        w_stats_rdata = DW'(r_ack_cnt[k]);
      end
    end
    if (w_word == c_ww'(N_SLV)) begin
      w_stats_rdata = DW'({r_tmo_cnt, r_miss_cnt});
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < N_SLV; k++) begin
        r_ack_cnt[k] <= '0;
      end
      r_miss_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else if (w_stats_acc && wbs_we_i) begin
      for (int k = 0; k < N_SLV; k++) begin
        r_ack_cnt[k] <= '0;
      end
      r_miss_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      for (int k = 0; k < N_SLV; k++) begin
        if (w_done && r_stb[k] && (r_ack_cnt[k] != 16'hFFFF)) begin
          r_ack_cnt[k] <= r_ack_cnt[k] + 16'd1;
        end
      end
      if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      if (w_tmo && (r_tmo_cnt != 16'hFFFF)) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_miss       = 1'b0;
    w_done       = 1'b0;
    w_tmo        = 1'b0;
    w_abort      = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_en      = 1'b0;
`ifdef WB_MUX_STATS_EN
    w_stats_acc  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_issue      = 1'b1;
            w_wd_clr     = 1'b1;
            w_state_next = S_BUSY;
`ifdef WB_MUX_STATS_EN
          end else if (w_stats_win) begin
            w_stats_acc  = 1'b1;
            w_state_next = S_RESP;
`endif
          end else begin
            w_miss       = 1'b1;
            w_state_next = S_RESP;
          end
        end
      end
      S_BUSY: begin
        // Abort outranks a same-cycle slave ack: the master has left.
        if (!wbs_cyc_i) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_sel_ack) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_wd_en = 1'b1;
          if (w_wd_expire) begin
            w_tmo        = 1'b1;
            w_state_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_stb   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_ack   <= 1'b0;
      r_rdat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_done | w_miss | w_tmo
`ifdef WB_MUX_STATS_EN
                 | w_stats_acc
`endif
                 ;
      if (w_issue) begin
        r_stb  <= w_onehot;
        r_we   <= wbs_we_i;
        r_sel  <= wbs_sel_i;
        r_adr  <= w_off[WIN_BITS-1:0];
        r_wdat <= wbs_dat_i;
      end
      if (w_done || w_tmo || w_abort) begin
        r_stb <= '0;
      end
      if (w_done) begin
        r_rdat <= r_we ? '0 : w_slv_rdata;
      end
      if (w_miss || w_tmo) begin
        r_rdat <= ERR_DATA;
        r_err  <= 1'b1;
      end
`ifdef WB_MUX_STATS_EN
      if (w_stats_acc) begin
        r_rdat <= wbs_we_i ? '0 : w_stats_rdata;
        if (wbs_we_i) begin
          r_err <= 1'b0;
        end
      end
`endif
    end
  end

  wb_mux_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clr    (w_wd_clr),
    .en     (w_wd_en),
    .expire (w_wd_expire)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_rdat;
  assign m_cyc_o   = r_stb;
  assign m_stb_o   = r_stb;
  assign m_we_o    = r_we;
  assign m_sel_o   = r_sel;
  assign m_adr_o   = r_adr;
  assign m_dat_o   = r_wdat;
  assign err_irq_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_slave_mux
// Brief    : Directed self-checking bench for wb_slave_mux (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_slave_mux;

  logic         clk;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [3:0]   m_cyc_o, m_stb_o;
  logic         m_we_o;
  logic [3:0]   m_sel_o;
  logic [19:0]  m_adr_o;
  logic [31:0]  m_dat_o;
  logic [127:0] m_dat_i;
  logic [3:0]   m_ack_i;
  logic         err_irq_o;

  int n_vec;
  int n_err;

  localparam logic [31:0] c_err = 32'hBADD_ADD0;

  wb_slave_mux dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_we_o    (m_we_o),
    .m_sel_o   (m_sel_o),
    .m_adr_o   (m_adr_o),
    .m_dat_o   (m_dat_o),
    .m_dat_i   (m_dat_i),
    .m_ack_i   (m_ack_i),
    .err_irq_o (err_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL sim_time_limit: observed hang expected completion");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Single access against zero-wait slaves; lat counts samples after T0.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, output logic [31:0] got, output int lat);
    req(w, a, 4'hF, wd);
    m_dat_i = {4{rd}};
    lat = -1;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      m_ack_i = m_stb_o;
      if (wbs_ack_o) begin
        lat = i;
        got = wbs_dat_o;
        break;
      end
    end
    drop();
    m_ack_i = '0;
    tick();
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    int          n;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
    m_dat_i = '0; m_ack_i = '0;
    repeat (2) tick();

    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_stb", {28'd0, m_stb_o}, 32'd0);
    check("rst_cyc", {28'd0, m_cyc_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_err", {31'd0, err_irq_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Read slave 2, ack in the third BUSY cycle
    req(1'b0, 32'h3020_0010, 4'hF, 32'd0);
    tick();
    check("rd2_stb", {28'd0, m_stb_o}, 32'h4);
    check("rd2_cyc", {28'd0, m_cyc_o}, 32'h4);
    check("rd2_adr", {12'd0, m_adr_o}, 32'h10);
    tick();
    check("rd2_wait_ack", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    m_ack_i = 4'b0100;
    m_dat_i[64 +: 32] = 32'h1234_5678;
    check("rd2_wait_ack3", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    m_ack_i = '0;
    drop();
    check("rd2_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("rd2_data", wbs_dat_o, 32'h1234_5678);
    check("rd2_stb_off", {28'd0, m_stb_o}, 32'd0);
    tick();
    check("rd2_ack_once", {31'd0, wbs_ack_o}, 32'd0);
    check("rd2_data_hold", wbs_dat_o, 32'h1234_5678);

    // Write slave 0 with partial byte selects
    req(1'b1, 32'h3000_0004, 4'b0011, 32'hCAFE_F00D);
    tick();
    check("wr0_stb", {28'd0, m_stb_o}, 32'h1);
    check("wr0_we", {31'd0, m_we_o}, 32'd1);
    check("wr0_sel", {28'd0, m_sel_o}, 32'h3);
    check("wr0_dat", m_dat_o, 32'hCAFE_F00D);
    check("wr0_adr", {12'd0, m_adr_o}, 32'h4);
    m_ack_i = 4'b0001;
    tick();
    m_ack_i = '0;
    drop();
    check("wr0_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("wr0_data", wbs_dat_o, 32'd0);
    tick();
    check("wr0_ack_once", {31'd0, wbs_ack_o}, 32'd0);
    check("wr0_err", {31'd0, err_irq_o}, 32'd0);

    // Decode miss above the last window
    req(1'b0, 32'h3050_0000, 4'hF, 32'd0);
    tick();
    check("miss_ack_t1", {31'd0, wbs_ack_o}, 32'd1);
    check("miss_data", wbs_dat_o, c_err);
    check("miss_err", {31'd0, err_irq_o}, 32'd1);
    check("miss_stb", {28'd0, m_stb_o}, 32'd0);
    drop();
    tick();
    check("miss_ack_once", {31'd0, wbs_ack_o}, 32'd0);
    check("miss_err_sticky", {31'd0, err_irq_o}, 32'd1);

    // Boundaries: just below base misses, top word of slave 3 hits
    xfer(1'b0, 32'h2FFF_FFFC, 32'd0, 32'h1111_1111, got, lat);
    check("below_base_data", got, c_err);
    check("below_base_lat", lat, 32'd0);
    xfer(1'b0, 32'h303F_FFFC, 32'd0, 32'h3333_CCCC, got, lat);
    check("top_s3_data", got, 32'h3333_CCCC);
    check("top_s3_lat", lat, 32'd1);

    // Master abort in BUSY
    req(1'b0, 32'h3030_0020, 4'hF, 32'd0);
    tick();
    check("abort_stb_on", {28'd0, m_stb_o}, 32'h8);
    drop();
    tick();
    check("abort_stb_off", {28'd0, m_stb_o}, 32'd0);
    check("abort_no_ack", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    check("abort_no_ack2", {31'd0, wbs_ack_o}, 32'd0);

    // Asynchronous reset mid-BUSY
    req(1'b0, 32'h3020_0000, 4'hF, 32'd0);
    tick();
    check("rstmid_idle_ok", {28'd0, m_stb_o}, 32'h4);
    tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_stb_async", {28'd0, m_stb_o}, 32'd0);
    check("rstmid_cyc_async", {28'd0, m_cyc_o}, 32'd0);
    check("rstmid_err", {31'd0, err_irq_o}, 32'd0);
    tick();
    check("rstmid_no_ack", {31'd0, wbs_ack_o}, 32'd0);
    drop();
    rst_n = 1'b1;
    tick();

    // Slave 1 never acks
    req(1'b0, 32'h3010_0000, 4'hF, 32'd0);
    n = 0;
    tick();
    while (m_stb_o == 4'b0010 && n < 400) begin
      n++;
      tick();
    end
    check("tmo_busy_cycles", n, 32'd255);
    check("tmo_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("tmo_data", wbs_dat_o, c_err);
    check("tmo_err", {31'd0, err_irq_o}, 32'd1);
    check("tmo_stb_off", {28'd0, m_stb_o}, 32'd0);
    drop();
    tick();
    check("tmo_ack_once", {31'd0, wbs_ack_o}, 32'd0);
    xfer(1'b0, 32'h3000_0008, 32'd0, 32'hA5A5_0001, got, lat);
    check("after_tmo_data", got, 32'hA5A5_0001);
    check("after_tmo_lat", lat, 32'd1);

`ifdef WB_MUX_STATS_EN
    xfer(1'b1, 32'h3040_0000, 32'd0, 32'd0, got, lat);
    check("st_clr_lat", lat, 32'd0);
    check("st_clr_err", {31'd0, err_irq_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h3000_0000, 32'd0, 32'h0BAD_F00D, got, lat);
    end
    xfer(1'b0, 32'h3050_0000, 32'd0, 32'd0, got, lat);
    xfer(1'b0, 32'h3040_0000, 32'd0, 32'd0, got, lat);
    check("st_s0_count", got, 32'd3);
    check("st_rd_lat", lat, 32'd0);
    xfer(1'b0, 32'h3040_0004, 32'd0, 32'd0, got, lat);
    check("st_s1_count", got, 32'd0);
    xfer(1'b0, 32'h3040_0010, 32'd0, 32'd0, got, lat);
    check("st_tmo_miss", got, 32'h0000_0001);
    check("st_err_set", {31'd0, err_irq_o}, 32'd1);
    xfer(1'b1, 32'h3040_0008, 32'd0, 32'd0, got, lat);
    check("st_wr_err_clr", {31'd0, err_irq_o}, 32'd0);
    xfer(1'b0, 32'h3040_0000, 32'd0, 32'd0, got, lat);
    check("st_s0_cleared", got, 32'd0);
    xfer(1'b0, 32'h3040_0010, 32'd0, 32'd0, got, lat);
    check("st_tm_cleared", got, 32'd0);
`else
    xfer(1'b0, 32'h3040_0000, 32'd0, 32'h5555_AAAA, got, lat);
    check("idx_n_miss_data", got, c_err);
    check("idx_n_miss_lat", lat, 32'd0);
    check("idx_n_miss_err", {31'd0, err_irq_o}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Parametrised Wishbone classic slave-side fan-out that sits between the user-project Wishbone port and N wrapped peripherals (HyperRAM controller plus future blocks).
- Next generation of the single-slave wrapper hookup: decodes the address into per-slave windows and forwards one transaction at a time.
- Registers all responses, answers unmapped addresses with an error pattern, and guards every slave with a watchdog so a hung peripheral cannot stall the management SoC.

Parameters:
N_SLV, 4, number of downstream slaves (1..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
BASE_ADDR, 32'h3000_0000, start of slave 0 window; aligned to 2^WIN_BITS
WIN_BITS, 20, log2 of each slave window size in bytes
TIMEOUT, 255, max cycles waiting for slave ack (1..65535)
ERR_DATA, 32'hBADD_ADD0, read data returned on decode miss or timeout

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous assert, active-low
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  master write enable
wbs_sel_i  in  DW/8  byte selects
wbs_adr_i  in  AW  byte address
wbs_dat_i  in  DW  write data
wbs_ack_o  out  1  acknowledge to master
wbs_dat_o  out  DW  read data to master
m_cyc_o  out  N_SLV  per-slave cycle
m_stb_o  out  N_SLV  per-slave strobe
m_we_o  out  1  shared write enable
m_sel_o  out  DW/8  shared byte selects
m_adr_o  out  WIN_BITS  shared in-window offset
m_dat_o  out  DW  shared write data
m_dat_i  in  N_SLV*DW  packed slave read data, slave k at [k*DW +: DW]
m_ack_i  in  N_SLV  per-slave acknowledge
err_irq_o  out  1  sticky error flag (miss or timeout)

Behaviour:
- Reset: all outputs 0; FSM IDLE; watchdog 0; err_irq_o 0. A reset mid-transaction drops all slave strobes immediately (asynchronous); no ack is issued.
- Decode: off = wbs_adr_i - BASE_ADDR, idx = off >> WIN_BITS. It is a hit when wbs_adr_i >= BASE_ADDR and idx < N_SLV.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On cyc&stb with a hit: latch idx, we, sel, off[WIN_BITS-1:0] and dat_i into the m_* registers; assert m_cyc_o[idx] and m_stb_o[idx] next cycle; clear the watchdog; go to BUSY.
  - On cyc&stb with a miss: load wbs_dat_o = ERR_DATA (written data is discarded); set err_irq_o; go to RESP.
- BUSY:
  - On m_ack_i[idx]: capture the m_dat_i slice (0 if we), deassert the slave strobes, go to RESP.
  - Acks from non-selected slaves are ignored.
  - Otherwise the watchdog increments. When it equals TIMEOUT: deassert strobes, load ERR_DATA, set err_irq_o, go to RESP.
  - If the master drops wbs_cyc_i (abort): deassert strobes, go to IDLE, no ack.
- RESP: wbs_ack_o = 1 for exactly one cycle with wbs_dat_o valid, then go to IDLE. wbs_dat_o holds its value until the next capture.
- Latency:
  - Hit: ack 2 cycles after the slave ack cycle minus one, i.e. request sampled at T0, slave strobe T1, slave ack at Tk, wbs_ack_o at Tk+1.
  - Miss: ack at T1.
- Back-to-back: a new request is sampled in the cycle after RESP. Minimum issue interval is 3 cycles for a hit with zero-wait slaves.
- At most one m_stb_o bit is set at any time (one-hot or zero).
- err_irq_o is cleared only by reset, or by the stats block when it is enabled.

Optional Feature:
- WB_MUX_STATS_EN defined:
  - Adds one extra window, idx == N_SLV, served internally with zero wait states (ack at T1).
  - Word k (k < N_SLV) reads a 16-bit saturating count of completed acks for slave k, zero-extended.
  - Word N_SLV reads {timeouts[15:0], misses[15:0]}.
  - Any write to this window clears all counters and err_irq_o.
  - Counters reset to 0.
- Undefined: idx == N_SLV is a decode miss; no counter logic is present; err_irq_o is reset-only.

Decomposition:
- Package wb_mux_pkg:
  - typedef of the FSM state enum;
  - localparam function for the window index width, clog2(N_SLV+1);
  - default ERR_DATA constant.
- One sub-module, wb_mux_watchdog: a loadable counter with clear, enable and expire outputs, parametrised by TIMEOUT.

Test Plan:
- Read slave 2 at 0x3020_0010, slave acks at its 3rd BUSY cycle with 0x1234_5678:
  - m_stb_o = 4'b0100 and m_adr_o = 0x10;
  - wbs_ack_o pulses once, next cycle, with wbs_dat_o = 0x1234_5678.
- Write 0xCAFE_F00D with sel = 4'b0011 to 0x3000_0004:
  - slave 0 sees we = 1, sel = 0011, dat = 0xCAFE_F00D;
  - single ack.
- Read 0x3050_0000 (idx 5 ≥ 4):
  - no m_stb_o asserted;
  - ack at T1 with 0xBADD_ADD0;
  - err_irq_o = 1.
- Slave 1 never acks (TIMEOUT = 255):
  - strobe drops after 255 BUSY cycles;
  - ack with ERR_DATA;
  - err_irq_o = 1;
  - next access to slave 0 completes normally.
- Master drops cyc in BUSY, and separately wb_rst_ni is pulsed low mid-BUSY:
  - strobes go 0;
  - no wbs_ack_o;
  - FSM back in IDLE.
- With WB_MUX_STATS_EN: 3 slave-0 reads and 1 miss, then read 0x3040_0000 → 3 and read 0x3040_0010 → 0x0000_0001; write to the window → counters and err_irq_o = 0.
